// File: rtl/dsp_wresp_channel_fifo.sv
// Synchronous FIFO used as the write-ordering queue: holds the slave index of
// every dispatched AW until its B response has been accepted.
module fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  // A pop frees a slot in the same cycle, so push at full succeeds only alongside a pop.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == DEPTH_CNT);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dsp_wresp_channel.sv
// Write-response channel of one master port: merges B responses from several
// slave arbiters back into AW dispatch order through a single output register.
module dsp_wresp_channel #(
  parameter int SLV_AMT         = 2,
  parameter int OUTSTANDING_AMT = 8,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int SLV_ID_W        = $clog2(SLV_AMT)
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]  sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                  sa_BVALID_i,
  output logic [SLV_AMT-1:0]                  sa_BREADY_o,
  input  logic [SLV_ID_W-1:0]                 AW_slv_id_i,
  input  logic                                AW_shift_en_i,
  output logic                                AW_stall_o,
  output logic [TRANS_MST_ID_W-1:0]           m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]          m_BRESP_o,
  output logic                                m_BVALID_o,
  input  logic                                m_BREADY_i
);

  logic [SLV_ID_W-1:0]        head_s;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       accept_s;
  logic                       handshake_s;
  logic                       bvalid_sel_s;
  logic [TRANS_MST_ID_W-1:0]  bid_sel_s;
  logic [TRANS_WR_RESP_W-1:0] bresp_sel_s;
  logic [SLV_AMT-1:0]         ready_s;
  logic                       m_bvalid_r;
  logic [TRANS_MST_ID_W-1:0]  m_bid_r;
  logic [TRANS_WR_RESP_W-1:0] m_bresp_r;

  fifo #(
    .DATA_WIDTH (SLV_ID_W),
    .FIFO_DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .push      (AW_shift_en_i),
    .push_data (AW_slv_id_i),
    .pop       (handshake_s),
    .pop_data  (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // The output register can take a new response when it is empty or draining this cycle.
  assign accept_s    = ~fifo_empty_s & (~m_bvalid_r | m_BREADY_i);
  assign handshake_s = bvalid_sel_s & accept_s;

  // Only the slave named by the FIFO head is offered BREADY; its channel is muxed out.
  always_comb begin
    bvalid_sel_s = 1'b0;
    bid_sel_s    = {TRANS_MST_ID_W{1'b0}};
    bresp_sel_s  = {TRANS_WR_RESP_W{1'b0}};
    ready_s      = {SLV_AMT{1'b0}};
    for (int s = 0; s < SLV_AMT; s++) begin
      if (head_s == SLV_ID_W'(s)) begin
        bvalid_sel_s = sa_BVALID_i[s];
        bid_sel_s    = sa_BID_i[TRANS_MST_ID_W*s +: TRANS_MST_ID_W];
        bresp_sel_s  = sa_BRESP_i[TRANS_WR_RESP_W*s +: TRANS_WR_RESP_W];
        ready_s[s]   = accept_s;
      end else begin
        ready_s[s]   = 1'b0;
      end
    end
  end

  // Master-side B register: loads on a slave handshake, clears when consumed.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      m_bvalid_r <= 1'b0;
      m_bid_r    <= {TRANS_MST_ID_W{1'b0}};
      m_bresp_r  <= {TRANS_WR_RESP_W{1'b0}};
    end else if (handshake_s) begin
      m_bvalid_r <= 1'b1;
      m_bid_r    <= bid_sel_s;
      m_bresp_r  <= bresp_sel_s;
    end else if (m_BREADY_i) begin
      m_bvalid_r <= 1'b0;
    end else begin
      m_bvalid_r <= m_bvalid_r;
    end
  end

  assign sa_BREADY_o = ready_s;
  assign AW_stall_o  = fifo_full_s;
  assign m_BVALID_o  = m_bvalid_r;
  assign m_BID_o     = m_bid_r;
  assign m_BRESP_o   = m_bresp_r;

endmodule

// File: doc/dsp_wresp_channel.md
DSP_WRESP_CHANNEL -- requirements
Module: dsp_wresp_channel

Interface
REQ-001 Parameter SLV_AMT, default 2, number of slave arbiters feeding this master port.
REQ-002 Parameter OUTSTANDING_AMT, default 8, depth of the write-ordering FIFO.
REQ-003 Parameter TRANS_MST_ID_W, default 5, width of the master transaction ID.
REQ-004 Parameter TRANS_WR_RESP_W, default 2, width of BRESP.
REQ-005 Parameter SLV_ID_W, default $clog2(SLV_AMT), width of the slave index.
REQ-006 Port ACLK_i, input, 1, the single clock; all logic is rising-edge.
REQ-007 Port ARESETn_i, input, 1, reset, synchronous and active-low.
REQ-008 Port sa_BID_i, input, TRANS_MST_ID_W*SLV_AMT, per-slave-arbiter BID, slice s is [TRANS_MST_ID_W*(s+1)-1 -: TRANS_MST_ID_W].
REQ-009 Port sa_BRESP_i, input, TRANS_WR_RESP_W*SLV_AMT, per-slave-arbiter BRESP, sliced the same way.
REQ-010 Port sa_BVALID_i, input, SLV_AMT, per-slave-arbiter BVALID.
REQ-011 Port sa_BREADY_o, output, SLV_AMT, per-slave-arbiter BREADY.
REQ-012 Port AW_slv_id_i, input, SLV_ID_W, slave index of the AW transfer being dispatched.
REQ-013 Port AW_shift_en_i, input, 1, AW dispatch strobe; one pulse per accepted AW.
REQ-014 Port AW_stall_o, output, 1, stalls AW dispatch while the ordering FIFO is full.
REQ-015 Port m_BID_o, output, TRANS_MST_ID_W, master-side BID.
REQ-016 Port m_BRESP_o, output, TRANS_WR_RESP_W, master-side BRESP.
REQ-017 Port m_BVALID_o, output, 1, master-side BVALID.
REQ-018 Port m_BREADY_i, input, 1, master-side BREADY.

Function
REQ-019 The block SHALL push AW_slv_id_i into the ordering FIFO on each cycle with AW_shift_en_i=1.
REQ-020 The head entry of the ordering FIFO SHALL select the only slave whose response may be accepted, which keeps write responses in AW order.
REQ-021 sa_BREADY_o[s] SHALL equal (s==head) & ~fifo_empty & (~m_BVALID_o | m_BREADY_i); all other bits SHALL be 0.
REQ-022 A slave handshake is sa_BVALID_i[head] & sa_BREADY_o[head]; on a slave handshake the FIFO SHALL pop and the output register SHALL load that slave's BID/BRESP.
REQ-023 m_BVALID_o SHALL rise on the cycle after a slave handshake (latency 1), with no combinational path from sa_* inputs to m_* outputs.
REQ-024 m_BVALID_o/m_BID_o/m_BRESP_o SHALL hold stable while m_BVALID_o=1 and m_BREADY_i=0.
REQ-025 On m_BVALID_o & m_BREADY_i with no new slave handshake, m_BVALID_o SHALL clear next cycle; with a simultaneous slave handshake the register SHALL reload (one response per cycle throughput).
REQ-026 A B response from a non-head slave SHALL be held off (BREADY=0) and SHALL NOT be dropped or reordered.
REQ-027 When the FIFO is empty, no BREADY SHALL assert, even if some sa_BVALID_i is high.
REQ-028 AW_stall_o SHALL equal fifo_full; a push while full is a protocol error and SHALL be ignored (FIFO contents unchanged).
REQ-029 A simultaneous push and pop SHALL both take effect; occupancy is unchanged, including at full and at occupancy 1.
REQ-030 A push to an empty FIFO SHALL NOT be poppable in the same cycle (no bypass).

Reset
REQ-031 While ARESETn_i=0 at a clock edge: FIFO empty, m_BVALID_o=0, m_BID_o=0, m_BRESP_o=0, AW_stall_o=0, sa_BREADY_o=0.
REQ-032 Reset asserted mid-transfer SHALL discard all pending ordering entries and any held response.

Structure
REQ-033 No package; the parameters are module-local, matching the sa_* channel blocks.
REQ-034 The ordering FIFO SHALL be an instance of the codebase's existing fifo module (DATA_WIDTH=SLV_ID_W, FIFO_DEPTH=OUTSTANDING_AMT); no other sub-module.

Verification
REQ-035 AW to slave 1, then sa_BVALID_i=2'b10, BID=5'h03, BRESP=2'b00 -> sa_BREADY_o=2'b10; next cycle m_BVALID_o=1, m_BID_o=5'h03.
REQ-036 AWs to slave 0 then slave 1; slave 1 responds first (BRESP=2'b10) -> held until slave 0's response reaches the master; master sees slave 0 then slave 1 responses.
REQ-037 Eight AWs with no responses -> AW_stall_o=1 after the 8th push; one pop plus a simultaneous push -> AW_stall_o stays 1.
REQ-038 m_BREADY_i=0 for 5 cycles with m_BVALID_o=1 -> outputs stable, sa_BREADY_o=0; release -> back-to-back responses delivered one per cycle.
REQ-039 sa_BVALID_i=2'b11 with the FIFO empty -> sa_BREADY_o=0 and m_BVALID_o=0.
REQ-040 ARESETn_i=0 for one cycle with 3 entries pending and m_BVALID_o=1 -> next cycle FIFO empty, m_BVALID_o=0, AW_stall_o=0.
